uart_tx_arb: RTL and testbench

UART_TX_ARB -- requirements
Module: uart_tx_arb

---
 rtl/uart_pkg.sv | 20 ++
 rtl/uart_tx_arb_if.sv | 29 ++
 rtl/uart_rr_pick.sv | 27 ++
 rtl/uart_tx_arb.sv | 137 +++++++++++++
 tb/tb_uart_tx_arb.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared UART arbiter definitions: FSM encoding, bit timing and parameter defaults.
// Combinational-only content; no latency or backpressure of its own.
package uart_pkg;

  localparam int UART_BIT_CYC    = 434;
  localparam int DEF_NREQ        = 4;
  localparam int DEF_TIMEOUT_CYC = 10 * UART_BIT_CYC;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    XFER    = 2'd1,
    RELEASE = 2'd2
  } state_t;

  // Width of a requester index; a 1-bit floor keeps degenerate sizes legal.
  function automatic int ptr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_tx_arb_if.sv
// Requester/transmitter bundle; master = arbiter side, slave = requesters and transmitter.
// Pure wiring: zero latency, backpressure carried by req_ready/tx_ready.
interface uart_tx_arb_if import uart_pkg::*; #(
  parameter int NREQ = DEF_NREQ
) ();

  logic [NREQ-1:0]   req_valid;
  logic [8*NREQ-1:0] req_data;
  logic [NREQ-1:0]   req_last;
  logic [NREQ-1:0]   req_ready;
  logic              tx_valid;
  logic [7:0]        tx_data;
  logic              tx_ready;
  logic [NREQ-1:0]   grant;
  logic              busy;
  logic              to_flag;
  logic              to_clr;

  modport master (
    input  req_valid, req_data, req_last, tx_ready, to_clr,
    output req_ready, tx_valid, tx_data, grant, busy, to_flag
  );

  modport slave (
    output req_valid, req_data, req_last, tx_ready, to_clr,
    input  req_ready, tx_valid, tx_data, grant, busy, to_flag
  );

endinterface

// File: rtl/uart_rr_pick.sv
// Round-robin picker: first request at or above rr_ptr, wrapping to 0.
// Combinational, zero latency; no backpressure.
module uart_rr_pick import uart_pkg::*; #(
  parameter int NREQ = DEF_NREQ,
  parameter int PW   = ptr_w(DEF_NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   rr_ptr,
  output logic [NREQ-1:0] win,
  output logic            any
);

  logic [PW-1:0] idx;

  always_comb begin
    win = '0;
    idx = '0;
    any = |req;
    for (int k = 0; k < NREQ; k++) begin
      idx = PW'((int'(rr_ptr) + k) % NREQ);
      if (win == '0 && req[idx]) begin
        win[idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arb.sv
// Packet-level round-robin arbiter of NREQ byte streams onto one UART transmitter; grant lags request by one cycle.
// Bytes pass combinationally from owner to tx under tx_ready backpressure; UART_ARB_TIMEOUT_EN adds a stall timeout.
module uart_tx_arb import uart_pkg::*; #(
  parameter int NREQ        = DEF_NREQ,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic          CLK_50,
  input  logic          nRST,
  uart_tx_arb_if.master bus
);

  localparam int PW = ptr_w(NREQ);

  state_t          state, state_nx;
  logic [NREQ-1:0] grant_q, grant_nx;
  logic [PW-1:0]   owner, owner_nx;
  logic [PW-1:0]   rr_ptr, rr_ptr_nx;
  logic [NREQ-1:0] pick_win;
  logic            pick_any;
  logic [PW-1:0]   pick_idx;
  logic            owner_vld;
  logic            owner_last;
  logic            handshake;
  logic            timeout_evt;
  logic            tx_valid_c;
  logic [7:0]      tx_data_c;
  logic [NREQ-1:0] req_ready_c;

  uart_rr_pick #(.NREQ(NREQ), .PW(PW)) u_pick (
    .req    (bus.req_valid),
    .rr_ptr (rr_ptr),
    .win    (pick_win),
    .any    (pick_any)
  );

  always_comb begin
    pick_idx = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (pick_win[k]) pick_idx = PW'(k);
    end
  end

  assign owner_vld  = bus.req_valid[owner];
  assign owner_last = bus.req_last[owner];
  assign handshake  = (state == XFER) && owner_vld && bus.tx_ready;

  always_ff @(posedge CLK_50 or negedge nRST) begin
    if (!nRST) begin
      state   <= IDLE;
      grant_q <= '0;
      owner   <= '0;
      rr_ptr  <= '0;
    end else begin
      state   <= state_nx;
      grant_q <= grant_nx;
      owner   <= owner_nx;
      rr_ptr  <= rr_ptr_nx;
    end
  end

  always_comb begin
    state_nx    = state;
    grant_nx    = grant_q;
    owner_nx    = owner;
    rr_ptr_nx   = rr_ptr;
    tx_valid_c  = 1'b0;
    tx_data_c   = '0;
    req_ready_c = '0;
    case (state)
      IDLE: begin
        if (pick_any) begin
          state_nx = XFER;
          grant_nx = pick_win;
          owner_nx = pick_idx;
        end
      end
      XFER: begin
        tx_valid_c         = owner_vld;
        tx_data_c          = bus.req_data[8*owner +: 8];
        req_ready_c[owner] = bus.tx_ready;
        if ((handshake && owner_last) || timeout_evt) begin
          state_nx = RELEASE;
          grant_nx = '0;
        end
      end
      RELEASE: begin
        state_nx  = IDLE;
        rr_ptr_nx = (owner == PW'(NREQ - 1)) ? '0 : owner + 1'b1;
      end
      default: begin
        state_nx = IDLE;
        grant_nx = '0;
      end
    endcase
  end

`ifdef UART_ARB_TIMEOUT_EN
  logic [12:0] stall_cnt;
  logic        to_flag_q;

  // Fires on the cycle that would make the stall count reach TIMEOUT_CYC.
  assign timeout_evt = (state == XFER) && !owner_vld &&
                       (stall_cnt == 13'(TIMEOUT_CYC - 1));

  always_ff @(posedge CLK_50 or negedge nRST) begin
    if (!nRST) begin
      stall_cnt <= '0;
      to_flag_q <= 1'b0;
    end else begin
      if (state != XFER || owner_vld || timeout_evt) begin
        stall_cnt <= '0;
      end else begin
        stall_cnt <= stall_cnt + 13'd1;
      end
      if (timeout_evt) begin
        to_flag_q <= 1'b1;
      end else if (bus.to_clr) begin
        to_flag_q <= 1'b0;
      end
    end
  end

  assign bus.to_flag = to_flag_q;
`else
  logic unused_to;
  assign unused_to   = ^{bus.to_clr, 13'(TIMEOUT_CYC)};
  assign timeout_evt = 1'b0;
  assign bus.to_flag = 1'b0;
`endif

  assign bus.tx_valid  = tx_valid_c;
  assign bus.tx_data   = tx_data_c;
  assign bus.req_ready = req_ready_c;
  assign bus.grant     = grant_q;
  assign bus.busy      = (state == XFER);

endmodule

// File: tb/tb_uart_tx_arb.sv
// Directed bench for uart_tx_arb: reset, round-robin order, byte streaming, reset abort, optional timeout.
module tb_uart_tx_arb;
  import uart_pkg::*;

  localparam int N = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  uart_tx_arb_if #(.NREQ(N)) bus ();

  uart_tx_arb #(.NREQ(N), .TIMEOUT_CYC(DEF_TIMEOUT_CYC)) dut (
    .CLK_50 (clk),
    .nRST   (rst_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic put(input int i, input logic [7:0] d, input logic v, input logic l);
    bus.req_data[8*i +: 8] = d;
    bus.req_valid[i]       = v;
    bus.req_last[i]        = l;
  endtask

  logic [7:0] exp_b [3];
  logic [3:0] exp_g;
  logic [7:0] exp_d;
  int         bi;
  int         n;

  initial begin
    exp_b[0] = 8'h41;
    exp_b[1] = 8'h42;
    exp_b[2] = 8'h43;
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.req_last  = '0;
    bus.tx_ready  = 1'b0;
    bus.to_clr    = 1'b0;
    #1 rst_n = 1'b0;
    bus.req_valid = 4'b1111;
    tick();
    tick();
    chk("rst_grant",     32'(bus.grant),     32'h0);
    chk("rst_busy",      32'(bus.busy),      32'h0);
    chk("rst_tx_valid",  32'(bus.tx_valid),  32'h0);
    chk("rst_tx_data",   32'(bus.tx_data),   32'h0);
    chk("rst_req_ready", 32'(bus.req_ready), 32'h0);
    chk("rst_to_flag",   32'(bus.to_flag),   32'h0);
    bus.req_valid = '0;
    rst_n = 1'b1;

    // Requesters 1 and 3, rr_ptr starts at 0
    put(1, 8'h11, 1'b1, 1'b1);
    put(3, 8'h33, 1'b1, 1'b1);
    settle();
    chk("t1_idle_grant", 32'(bus.grant), 32'h0);
    chk("t1_idle_txv",   32'(bus.tx_valid), 32'h0);
    tick();
    chk("t1_grant",     32'(bus.grant),     32'b0010);
    chk("t1_busy",      32'(bus.busy),      32'h1);
    chk("t1_txv",       32'(bus.tx_valid),  32'h1);
    chk("t1_txd",       32'(bus.tx_data),   32'h11);
    chk("t1_rdy_low",   32'(bus.req_ready), 32'h0);
    bus.tx_ready = 1'b1;
    settle();
    chk("t1_rdy",       32'(bus.req_ready), 32'b0010);
    tick();
    bus.req_valid[1] = 1'b0;
    settle();
    chk("t1_rel_grant", 32'(bus.grant),    32'h0);
    chk("t1_rel_busy",  32'(bus.busy),     32'h0);
    chk("t1_rel_txv",   32'(bus.tx_valid), 32'h0);
    tick();
    chk("t1_idle2_grant", 32'(bus.grant), 32'h0);
    tick();
    chk("t1_next_grant", 32'(bus.grant),   32'b1000);
    chk("t1_next_txd",   32'(bus.tx_data), 32'h33);
    tick();
    bus.req_valid[3] = 1'b0;
    bus.tx_ready     = 1'b0;
    tick();

    // Requester 0 streams three bytes while requester 1 waits
    put(0, 8'h41, 1'b1, 1'b0);
    put(1, 8'h99, 1'b1, 1'b1);
    tick();
    bi = 0;
    for (int c = 0; c < 12 && bi < 3; c++) begin
      bus.tx_ready       = (c % 2 == 1);
      bus.req_data[7:0]  = exp_b[bi];
      bus.req_last[0]    = (bi == 2);
      settle();
      chk("t2_grant", 32'(bus.grant),     32'b0001);
      chk("t2_txd",   32'(bus.tx_data),   32'(exp_b[bi]));
      chk("t2_rdy",   32'(bus.req_ready), bus.tx_ready ? 32'h1 : 32'h0);
      tick();
      if (bus.tx_ready) bi++;
    end
    chk("t2_bytes", 32'(bi), 32'd3);
    bus.req_valid[0] = 1'b0;
    settle();
    chk("t2_rel_grant", 32'(bus.grant),    32'h0);
    chk("t2_rel_txv",   32'(bus.tx_valid), 32'h0);
    tick();
    tick();
    chk("t2_r1_grant", 32'(bus.grant),   32'b0010);
    chk("t2_r1_txd",   32'(bus.tx_data), 32'h99);
    bus.tx_ready = 1'b1;
    tick();
    bus.req_valid = '0;
    bus.tx_ready  = 1'b0;
    tick();

    // Fresh reset, then all four send single-byte packets back to back
    rst_n = 1'b0;
    settle();
    rst_n = 1'b1;
    for (int i = 0; i < N; i++) put(i, 8'hA0 + 8'(i), 1'b1, 1'b1);
    bus.tx_ready = 1'b1;
    for (int c = 0; c < 13; c++) begin
      tick();
      exp_g = (c % 3 == 0) ? 4'(1 << ((c / 3) % 4)) : 4'h0;
      exp_d = 8'hA0 + 8'((c / 3) % 4);
      chk("t3_grant", 32'(bus.grant),    32'(exp_g));
      chk("t3_txv",   32'(bus.tx_valid), (c % 3 == 0) ? 32'h1 : 32'h0);
      if (c % 3 == 0) chk("t3_txd", 32'(bus.tx_data), 32'(exp_d));
    end
    tick();
    bus.req_valid = '0;
    tick();

    // Reset mid-packet from requester 2
    put(2, 8'hC2, 1'b1, 1'b0);
    tick();
    chk("t4_grant", 32'(bus.grant),    32'b0100);
    chk("t4_txv",   32'(bus.tx_valid), 32'h1);
    tick();
    chk("t4_hold",  32'(bus.grant),    32'b0100);
    rst_n = 1'b0;
    settle();
    chk("t4_rst_txv",   32'(bus.tx_valid), 32'h0);
    chk("t4_rst_grant", 32'(bus.grant),    32'h0);
    chk("t4_rst_busy",  32'(bus.busy),     32'h0);
    put(1, 8'h5A, 1'b1, 1'b0);
    put(2, 8'hC2, 1'b1, 1'b0);
    tick();
    chk("t4_rst_hold", 32'(bus.grant), 32'h0);
    rst_n = 1'b1;
    tick();
    chk("t4_grant2", 32'(bus.grant),   32'b0010);
    chk("t4_txd2",   32'(bus.tx_data), 32'h5A);

`ifdef UART_ARB_TIMEOUT_EN
    // Owner 1 stalls: release after exactly TIMEOUT_CYC low cycles
    bus.req_valid = '0;
    n = 0;
    while (bus.busy && n < 5000) begin
      tick();
      n++;
    end
    chk("to_cycles", 32'(n),           32'd4340);
    chk("to_flag",   32'(bus.to_flag), 32'h1);
    tick();
    bus.to_clr = 1'b1;
    tick();
    bus.to_clr = 1'b0;
    chk("to_clr", 32'(bus.to_flag), 32'h0);
    put(0, 8'h01, 1'b1, 1'b0);
    tick();
    chk("to_grant0", 32'(bus.grant), 32'b0001);
    bus.req_valid = '0;
    repeat (4339) tick();
    chk("to_busy_pre", 32'(bus.busy), 32'h1);
    bus.to_clr = 1'b1;
    tick();
    bus.to_clr = 1'b0;
    chk("to_busy_post", 32'(bus.busy),    32'h0);
    chk("to_set_wins",  32'(bus.to_flag), 32'h1);
`else
    bus.to_clr = 1'b1;
    tick();
    bus.to_clr = 1'b0;
    chk("to_tied", 32'(bus.to_flag), 32'h0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
